// File: rtl/picoram_uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// divider register write helper (lane merge with minimum clamp).
package picoram_uart_tx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned DIV_MIN   = 2;
    localparam int unsigned DIV_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Merge enabled byte lanes into the current divider; never store below DIV_MIN.
    function automatic logic [DIV_W-1:0] div_merge(input logic [DIV_W-1:0] cur,
                                                   input logic [3:0]       we,
                                                   input logic [DIV_W-1:0] di);
        logic [DIV_W-1:0] v;
        v = cur;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) v[8*i +: 8] = di[8*i +: 8];
        end
        if (v < DIV_W'(DIV_MIN)) v = DIV_W'(DIV_MIN);
        return v;
    endfunction

endpackage

// File: rtl/picoram_uart_tx_if.sv
// SoC register-bus side of the UART transmitter.
//   reg_div_we/di/do : divider register byte-lane write and readback
//   reg_dat_we/di    : byte push into the TX FIFO
//   reg_dat_wait     : bus stall while a push targets a full FIFO
interface picoram_uart_tx_if;
    logic [3:0]  reg_div_we;
    logic [31:0] reg_div_di;
    logic [31:0] reg_div_do;
    logic        reg_dat_we;
    logic [7:0]  reg_dat_di;
    logic        reg_dat_wait;

    modport master (
        output reg_div_we, reg_div_di, reg_dat_we, reg_dat_di,
        input  reg_div_do, reg_dat_wait
    );

    modport slave (
        input  reg_div_we, reg_div_di, reg_dat_we, reg_dat_di,
        output reg_div_do, reg_dat_wait
    );
endinterface

// File: rtl/picoram_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; full/empty from pointer compare.
//   push/din  : write when not full
//   pop/dout  : dout is the head entry, advanced when pop and not empty
//   level     : entries queued, full/empty flags derived from registered pointers
module picoram_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage, no reset needed: entries are only read once written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/picoram_uart_tx.sv
// UART transmitter: bus-written bytes are queued in a FIFO and sent 8N1
// (STOP_BITS configurable) on ser_tx, LSB first, div clk per bit.
//   clk, resetn : clock, async active-low reset
//   bus         : register bus (divider register, data push, wait)
//   fifo_level  : bytes queued
//   tx_busy     : FIFO non-empty or frame in progress (registered)
//   ser_tx      : serial line, idle high (registered)
module picoram_uart_tx
    import picoram_uart_tx_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned DIV_RESET  = 106,
    parameter  int unsigned STOP_BITS  = 1,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    picoram_uart_tx_if.slave   bus,
    output logic [LVL_W-1:0]   fifo_level,
    output logic               tx_busy,
    output logic               ser_tx
);

    uart_state_e      state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_frame;
    logic [DIV_W-1:0] timer;
    logic [DIV_W-1:0] stop_len;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic             timer_zero;
    logic             pop_c;
    logic             push_ok_c;
    logic [LVL_W:0]   level_next_c;
    logic             busy_next_c;

    assign bus.reg_div_do   = div_q;
    assign bus.reg_dat_wait = bus.reg_dat_we & fifo_full;

    assign timer_zero = (timer == '0);
    assign stop_len   = DIV_W'(STOP_BITS) * div_frame;

    // Pop on an idle line, or on the final stop cycle for zero-gap back-to-back frames
    assign pop_c     = ~fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && timer_zero));
    assign push_ok_c = bus.reg_dat_we & ~fifo_full;

    // Busy value after this edge: frame continuing/starting or FIFO still holding data
    assign level_next_c = {1'b0, fifo_level} + (LVL_W+1)'(push_ok_c) - (LVL_W+1)'(pop_c);
    assign busy_next_c  = pop_c || (level_next_c != '0) ||
                          ((state != ST_IDLE) && !(state == ST_STOP && timer_zero));

    picoram_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (bus.reg_dat_we),
        .pop    (pop_c),
        .din    (bus.reg_dat_di),
        .dout   (fifo_dout),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Divider register, bit timer, bit counter, FSM and line driver
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            ser_tx    <= 1'b1;
            tx_busy   <= 1'b0;
            div_q     <= DIV_W'(DIV_RESET);
            div_frame <= DIV_W'(DIV_RESET);
            timer     <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
        end else begin
            tx_busy <= busy_next_c;
            if (|bus.reg_div_we) div_q <= div_merge(div_q, bus.reg_div_we, bus.reg_div_di);

            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        shift     <= fifo_dout;
                        ser_tx    <= 1'b0;
                        div_frame <= div_q;
                        timer     <= div_q - DIV_W'(1);
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_zero) begin
                        ser_tx  <= shift[0];
                        bit_cnt <= '0;
                        timer   <= div_frame - DIV_W'(1);
                        state   <= ST_DATA;
                    end else begin
                        timer <= timer - DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_zero) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            ser_tx <= 1'b1;
                            timer  <= stop_len - DIV_W'(1);
                            state  <= ST_STOP;
                        end else begin
                            ser_tx  <= shift[1];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                            timer   <= div_frame - DIV_W'(1);
                        end
                    end else begin
                        timer <= timer - DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (timer_zero) begin
                        if (pop_c) begin
                            shift     <= fifo_dout;
                            ser_tx    <= 1'b0;
                            div_frame <= div_q;
                            timer     <= div_q - DIV_W'(1);
                            state     <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        timer <= timer - DIV_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picoram_uart_tx.sv
// Directed bench for picoram_uart_tx with an independent serial line receiver.
module tb_picoram_uart_tx;

    logic       clk;
    logic       resetn;
    logic [2:0] fifo_level;
    logic       tx_busy;
    logic       ser_tx;

    picoram_uart_tx_if bus ();

    picoram_uart_tx #(
        .FIFO_DEPTH (4),
        .DIV_RESET  (106),
        .STOP_BITS  (1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus.slave),
        .fifo_level (fifo_level),
        .tx_busy    (tx_busy),
        .ser_tx     (ser_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Line receiver: samples mid-bit using the divider the bench expects for the frame
    int         rx_div = 106;
    logic [7:0] rx_b[$];
    int         rx_t[$];
    logic       rx_s[$];
    logic       rx_prev;
    int         rx_d;
    int         rx_t0;
    int         rx_k;
    logic [7:0] rx_byte;

    initial begin : rx_mon
        rx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_prev && !ser_tx) begin
                rx_d  = rx_div;
                rx_t0 = cyc;
                rx_k  = 0;
                for (int i = 0; i < 8; i++) begin
                    while (rx_k < (i + 1) * rx_d + rx_d / 2) begin
                        @(negedge clk);
                        rx_k++;
                    end
                    rx_byte[i] = ser_tx;
                end
                while (rx_k < 9 * rx_d + rx_d / 2) begin
                    @(negedge clk);
                    rx_k++;
                end
                rx_b.push_back(rx_byte);
                rx_t.push_back(rx_t0);
                rx_s.push_back(ser_tx);
            end
            rx_prev = ser_tx;
        end
    end

    int last_t = 0;
    int prev_t = 0;

    task automatic pop_frame(input string tag, input logic [7:0] exp);
        logic [31:0] b;
        logic        s;
        if (rx_b.size() > 0) begin
            b = 32'(rx_b.pop_front());
            s = rx_s.pop_front();
            prev_t = last_t;
            last_t = rx_t.pop_front();
        end else begin
            b = 32'hDEAD_BEEF;
            s = 1'b0;
        end
        chk({tag, "_byte"}, b, 32'(exp));
        chk({tag, "_stop"}, 32'(s), 32'd1);
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int t = 0;
        while (rx_b.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_rx_count"}, 32'(rx_b.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while (tx_busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_idle"}, 32'(tx_busy), 32'd0);
    endtask

    // Presents a byte from a negedge and returns just after the accepting edge; we stays high
    task automatic push(input logic [7:0] b, output int waits);
        waits = 0;
        @(negedge clk);
        bus.reg_dat_we = 1'b1;
        bus.reg_dat_di = b;
        #1;
        while (bus.reg_dat_wait && waits < 20000) begin
            waits++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
    endtask

    task automatic release_we();
        @(negedge clk);
        bus.reg_dat_we = 1'b0;
    endtask

    task automatic div_write(input logic [3:0] we, input logic [31:0] di);
        @(negedge clk);
        bus.reg_div_we = we;
        bus.reg_div_di = di;
        @(negedge clk);
        bus.reg_div_we = 4'b0000;
    endtask

    int   w;
    int   n;
    logic low_seen;

    initial begin
        resetn         = 1'b0;
        bus.reg_div_we = 4'b0000;
        bus.reg_div_di = '0;
        bus.reg_dat_we = 1'b0;
        bus.reg_dat_di = '0;

        // 1: reset values
        repeat (3) @(negedge clk);
        chk("rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("rst_div", bus.reg_div_do, 32'd106);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 2: single byte 'A'
        push(8'h41, w);
        release_we();
        chk("single_ser_pre", 32'(ser_tx), 32'd1);
        chk("single_level_pre", 32'(fifo_level), 32'd1);
        @(negedge clk);
        chk("single_ser_start", 32'(ser_tx), 32'd0);
        chk("single_level", 32'(fifo_level), 32'd0);
        chk("single_busy", 32'(tx_busy), 32'd1);
        n = 0;
        while (tx_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("single_busy_len", 32'(n), 32'd1060);
        wait_rx("single", 1, 100);
        pop_frame("single", 8'h41);

        // 3: burst of six bytes into a four-deep FIFO
        for (int i = 0; i < 5; i++) begin
            push(8'h30 + 8'(i), w);
            #1;
            chk("burst_nowait", 32'(w), 32'd0);
        end
        chk("burst_full_level", 32'(fifo_level), 32'd4);
        push(8'h35, w);
        chk("burst_wait_cycles", 32'(w), 32'd1057);
        release_we();
        wait_rx("burst", 6, 8000);
        for (int i = 0; i < 6; i++) begin
            pop_frame($sformatf("burst%0d", i), 8'h30 + 8'(i));
            if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(last_t - prev_t), 32'd1060);
        end
        wait_idle("burst", 2000);

        // 4: divider write mid-frame applies to the next frame only
        push(8'h55, w);
        release_we();
        repeat (1 + 3 * 106 + 50) @(negedge clk);
        div_write(4'b0001, 32'd32);
        chk("div_readback", bus.reg_div_do, 32'd32);
        rx_div = 32;
        push(8'hA5, w);
        release_we();
        wait_rx("div", 2, 3000);
        pop_frame("div_old", 8'h55);
        pop_frame("div_new", 8'hA5);
        chk("div_gap", 32'(last_t - prev_t), 32'd1060);
        n = 0;
        while (tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("div_new_len", 32'(cyc - last_t), 32'd320);
        div_write(4'b1111, 32'd0);
        chk("div_clamp", bus.reg_div_do, 32'd2);
        div_write(4'b1111, 32'd106);
        chk("div_restore", bus.reg_div_do, 32'd106);
        rx_div = 106;
        repeat (5) @(negedge clk);

        // 6: simultaneous push and pop keep the level constant
        @(negedge clk);
        bus.reg_dat_we = 1'b1;
        bus.reg_dat_di = 8'h11;
        @(negedge clk);
        bus.reg_dat_di = 8'h22;
        chk("lvl_after_first", 32'(fifo_level), 32'd1);
        @(negedge clk);
        bus.reg_dat_we = 1'b0;
        chk("lvl_idle_pushpop", 32'(fifo_level), 32'd1);
        chk("lvl_start", 32'(ser_tx), 32'd0);
        repeat (1059) @(negedge clk);
        chk("lvl_stop_bit", 32'(ser_tx), 32'd1);
        chk("lvl_before_boundary", 32'(fifo_level), 32'd1);
        bus.reg_dat_we = 1'b1;
        bus.reg_dat_di = 8'h33;
        @(negedge clk);
        bus.reg_dat_we = 1'b0;
        chk("lvl_boundary_pushpop", 32'(fifo_level), 32'd1);
        chk("lvl_next_start", 32'(ser_tx), 32'd0);
        wait_rx("lvl", 3, 4000);
        pop_frame("lvl0", 8'h11);
        pop_frame("lvl1", 8'h22);
        chk("lvl_gap1", 32'(last_t - prev_t), 32'd1060);
        pop_frame("lvl2", 8'h33);
        chk("lvl_gap2", 32'(last_t - prev_t), 32'd1060);
        wait_idle("lvl", 2000);

        // 5: reset in the middle of data bit 3 of 0xC3 with two bytes queued
        push(8'hC3, w);
        push(8'h3C, w);
        push(8'h99, w);
        release_we();
        repeat (4 * 106 + 50) @(negedge clk);
        chk("rmf_level", 32'(fifo_level), 32'd2);
        chk("rmf_bit3", 32'(ser_tx), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("rmf_ser_tx", 32'(ser_tx), 32'd1);
        chk("rmf_level_rst", 32'(fifo_level), 32'd0);
        chk("rmf_busy_rst", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (!ser_tx) low_seen = 1'b1;
        end
        chk("rmf_line_idle", 32'(low_seen), 32'd0);
        chk("rmf_level_after", 32'(fifo_level), 32'd0);
        chk("rmf_busy_after", 32'(tx_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
